// File: rtl/tdc_readout_arbiter.sv
// -----------------------------------------------------------------------------
// tdc_readout_arbiter
// Round-robin readout sequencer for NUM_CHAN TDC channels that share one event
// output path. A pending channel is granted, its rising/falling stamps are
// latched, its clear is pulsed for one cycle, and a single record is offered
// on a valid/ready handshake.
//
// Optional feature macro: TDC_ARB_TOT_CALC_EN
//   defined   : evt_tot = falling - rising (modulo 2^TS_WIDTH)
//   undefined : evt_tot = raw falling stamp, no subtractor
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   chan_enable     per-channel arbitration enable
//   chan_has_event  per-channel event-pending flag
//   chan_timestamp  packed rising stamps, channel i at [i*TS_WIDTH +: TS_WIDTH]
//   chan_falling    packed falling stamps, same packing
//   chan_clear      one-hot clear pulse to the granted channel
//   evt_valid/ready record handshake
//   evt_chan        channel index of the record
//   evt_timestamp   latched rising stamp
//   evt_tot         time-over-threshold or raw falling stamp
//   evt_count       records accepted since reset (wraps)
//   busy            FSM not in IDLE
// -----------------------------------------------------------------------------
module tdc_readout_arbiter #(
    parameter int NUM_CHAN  = 4,
    parameter int TS_WIDTH  = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CHAN-1:0]          chan_enable,
    input  logic [NUM_CHAN-1:0]          chan_has_event,
    input  logic [NUM_CHAN*TS_WIDTH-1:0] chan_timestamp,
    input  logic [NUM_CHAN*TS_WIDTH-1:0] chan_falling,
    output logic [NUM_CHAN-1:0]          chan_clear,
    output logic                         evt_valid,
    input  logic                         evt_ready,
    output logic [$clog2(NUM_CHAN)-1:0]  evt_chan,
    output logic [TS_WIDTH-1:0]          evt_timestamp,
    output logic [TS_WIDTH-1:0]          evt_tot,
    output logic [CNT_WIDTH-1:0]         evt_count,
    output logic                         busy
);

    localparam int CW = $clog2(NUM_CHAN);

    typedef enum logic [1:0] {IDLE, CLEAR, PRESENT} state_t;

    state_t            state;
    logic [CW-1:0]     last_grant;
    logic [CW-1:0]     next_grant;
    logic              found;
    logic [NUM_CHAN-1:0] pending;
    logic [TS_WIDTH-1:0] ts_sel;
    logic [TS_WIDTH-1:0] fall_sel;
    logic [TS_WIDTH-1:0] tot_sel;
    int                idx;

    assign pending = chan_has_event & chan_enable;

    // Search last_grant+1, last_grant+2, ... wrapping at NUM_CHAN; first hit wins.
    always_comb begin
        next_grant = '0;
        found      = 1'b0;
        idx        = 0;
        for (int i = 1; i <= NUM_CHAN; i++) begin
            idx = int'(last_grant) + i;
            if (idx >= NUM_CHAN) idx = idx - NUM_CHAN;
            if (!found && pending[idx]) begin
                found      = 1'b1;
                next_grant = CW'(idx);
            end
        end
    end

    always_comb begin
        ts_sel   = chan_timestamp[next_grant*TS_WIDTH +: TS_WIDTH];
        fall_sel = chan_falling[next_grant*TS_WIDTH +: TS_WIDTH];
`ifdef TDC_ARB_TOT_CALC_EN
        // Modulo subtraction gives the right duration across a counter wrap.
        tot_sel  = fall_sel - ts_sel;
`else
        tot_sel  = fall_sel;
`endif
    end

    // Decoded from registered state/grant only, so the pulse is glitch-free.
    always_comb begin
        chan_clear = '0;
        for (int i = 0; i < NUM_CHAN; i++)
            chan_clear[i] = (state == CLEAR) && (evt_chan == CW'(i));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            last_grant    <= CW'(NUM_CHAN - 1);
            evt_chan      <= '0;
            evt_timestamp <= '0;
            evt_tot       <= '0;
            evt_valid     <= 1'b0;
            evt_count     <= '0;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        evt_chan      <= next_grant;
                        evt_timestamp <= ts_sel;
                        evt_tot       <= tot_sel;
                        busy          <= 1'b1;
                        state         <= CLEAR;
                    end
                end
                CLEAR: begin
                    // Record completes even if the channel is disabled meanwhile.
                    last_grant <= evt_chan;
                    evt_valid  <= 1'b1;
                    state      <= PRESENT;
                end
                PRESENT: begin
                    if (evt_ready) begin
                        evt_valid <= 1'b0;
                        evt_count <= evt_count + 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    evt_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_readout_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tdc_readout_arbiter
// Directed-vector bench for tdc_readout_arbiter (NUM_CHAN=4, TS_WIDTH=32,
// CNT_WIDTH=16). Expected values are hand-computed in the stimulus; evt_tot
// expectations follow TDC_ARB_TOT_CALC_EN.
// -----------------------------------------------------------------------------
module tb_tdc_readout_arbiter;

    localparam int NC = 4;
    localparam int TW = 32;
    localparam int KW = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [NC-1:0]     chan_enable;
    logic [NC-1:0]     chan_has_event;
    logic [NC*TW-1:0]  chan_timestamp;
    logic [NC*TW-1:0]  chan_falling;
    logic [NC-1:0]     chan_clear;
    logic              evt_valid;
    logic              evt_ready;
    logic [1:0]        evt_chan;
    logic [TW-1:0]     evt_timestamp;
    logic [TW-1:0]     evt_tot;
    logic [KW-1:0]     evt_count;
    logic              busy;

    int vectors     = 0;
    int miscompares = 0;
    int exp_cnt     = 0;

    tdc_readout_arbiter #(.NUM_CHAN(NC), .TS_WIDTH(TW), .CNT_WIDTH(KW)) dut (
        .clk(clk), .reset(reset),
        .chan_enable(chan_enable), .chan_has_event(chan_has_event),
        .chan_timestamp(chan_timestamp), .chan_falling(chan_falling),
        .chan_clear(chan_clear), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_chan(evt_chan), .evt_timestamp(evt_timestamp), .evt_tot(evt_tot),
        .evt_count(evt_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [TW-1:0] exp_tot(input logic [TW-1:0] r, input logic [TW-1:0] f);
`ifdef TDC_ARB_TOT_CALC_EN
        return f - r;
`else
        return f + 0 * r;
`endif
    endfunction

    task automatic set_stamp(input int ch, input logic [TW-1:0] r, input logic [TW-1:0] f);
        chan_timestamp[ch*TW +: TW] = r;
        chan_falling[ch*TW +: TW]   = f;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_clear"}, 64'(chan_clear), 64'd0);
        chk({tag, "_valid"}, 64'(evt_valid), 64'd0);
        chk({tag, "_busy"},  64'(busy), 64'd0);
        chk({tag, "_count"}, 64'(evt_count), 64'd0);
        chk({tag, "_chan"},  64'(evt_chan), 64'd0);
        chk({tag, "_ts"},    64'(evt_timestamp), 64'd0);
        chk({tag, "_tot"},   64'(evt_tot), 64'd0);
    endtask

    // Wait for the clear pulse, check it and the record that follows.
    // stall = cycles evt_ready is held low in PRESENT; rearm keeps has_event up.
    task automatic serve(input string tag, input int ch, input logic [TW-1:0] r,
                         input logic [TW-1:0] f, input int stall, input bit rearm);
        int k;
        k = 0;
        while (chan_clear == '0 && k < 20) begin
            tick();
            k++;
        end
        if (chan_clear == '0) begin
            chk({tag, "_timeout"}, 64'd0, 64'd1);
            return;
        end
        chk({tag, "_clear"}, 64'(chan_clear), 64'(4'b0001 << ch));
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_nvld"}, 64'(evt_valid), 64'd0);
        if (!rearm) chan_has_event[ch] = 1'b0;
        evt_ready = (stall == 0);
        tick();
        for (int s = 0; s <= stall; s++) begin
            if (s == stall) evt_ready = 1'b1;
            chk({tag, "_valid"}, 64'(evt_valid), 64'd1);
            chk({tag, "_chan"},  64'(evt_chan), 64'(ch));
            chk({tag, "_ts"},    64'(evt_timestamp), 64'(r));
            chk({tag, "_tot"},   64'(evt_tot), 64'(exp_tot(r, f)));
            chk({tag, "_noclr"}, 64'(chan_clear), 64'd0);
            tick();
        end
        exp_cnt++;
        chk({tag, "_count"}, 64'(evt_count), 64'(exp_cnt));
        chk({tag, "_vdone"}, 64'(evt_valid), 64'd0);
    endtask

    initial begin
        reset          = 1'b1;
        chan_enable    = '1;
        chan_has_event = '0;
        chan_timestamp = '0;
        chan_falling   = '0;
        evt_ready      = 1'b1;
        #12;
        check_idle_outputs("rst");
        reset = 1'b0;
        tick();

        // single event on ch2
        set_stamp(2, 32'd100, 32'd350);
        chan_has_event = 4'b0100;
        serve("single", 2, 32'd100, 32'd350, 0, 1'b0);

        // round robin after a fresh reset: order 0,1,3,0,1,3
        reset = 1'b1; #1; reset = 1'b0; exp_cnt = 0;
        tick();
        for (int c = 0; c < NC; c++) set_stamp(c, 32'(1000 + 16 * c), 32'(1500 + 16 * c));
        chan_has_event = 4'b1011;
        serve("rr0a", 0, 32'd1000, 32'd1500, 0, 1'b1);
        serve("rr1a", 1, 32'd1016, 32'd1516, 0, 1'b1);
        serve("rr3a", 3, 32'd1048, 32'd1548, 0, 1'b1);
        serve("rr0b", 0, 32'd1000, 32'd1500, 0, 1'b0);
        serve("rr1b", 1, 32'd1016, 32'd1516, 0, 1'b0);
        serve("rr3b", 3, 32'd1048, 32'd1548, 0, 1'b0);

        // backpressure: 10 stalled cycles on ch2
        set_stamp(2, 32'h0000_1234, 32'h0000_2000);
        chan_has_event = 4'b0100;
        serve("bp", 2, 32'h0000_1234, 32'h0000_2000, 10, 1'b0);

        // mask: ch1 pending but disabled
        chan_enable    = 4'b1101;
        chan_has_event = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mask_clear", 64'(chan_clear), 64'd0);
            chk("mask_busy",  64'(busy), 64'd0);
        end
        chk("mask_hold", 64'(chan_has_event), 64'd2);
        chan_enable = 4'b1111;
        serve("unmask", 1, 32'd1016, 32'd1516, 0, 1'b0);

        // counter wrap between edges
        set_stamp(0, 32'hFFFF_FFF0, 32'h0000_0010);
        chan_has_event = 4'b0001;
        serve("wrap", 0, 32'hFFFF_FFF0, 32'h0000_0010, 0, 1'b0);
`ifdef TDC_ARB_TOT_CALC_EN
        chk("wrap_tot20", 64'(evt_tot), 64'h20);
`endif

        // reset while in CLEAR: ch3 keeps its event and is re-served
        set_stamp(3, 32'd777, 32'd900);
        chan_has_event = 4'b1000;
        tick();
        chk("rclr_clear", 64'(chan_clear), 64'b1000);
        reset = 1'b1;
        #1;
        check_idle_outputs("rclr");
        #2;
        reset = 1'b0;
        exp_cnt = 0;
        serve("reserve", 3, 32'd777, 32'd900, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
